// File: rtl/pio_mem_bram_mc.sv
// 1R1W block-RAM lookup table shared by NCH application read channels and a PIO bus.
// PIO writes go straight to the RAM; reads are arbitrated one per cycle with a bounded PIO wait.
module pio_mem_bram_mc #(
    parameter int WIDTH        = 20,
    parameter int DEPTH_NBITS  = 10,
    parameter int NCH          = 2,
    parameter int PIO_MAX_WAIT = 4,
    parameter int PIO_NBITS    = 32,
    parameter int PIO_ADDR_MSB = PIO_NBITS - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_div,
    input  logic [PIO_NBITS-1:0]         reg_addr,
    input  logic [PIO_NBITS-1:0]         reg_din,
    input  logic                         reg_rd,
    input  logic                         reg_wr,
    input  logic                         reg_ms,
    output logic                         mem_ack,
    output logic [PIO_NBITS-1:0]         mem_rdata,
    input  logic [NCH-1:0]               app_mem_rd,
    input  logic [NCH*DEPTH_NBITS-1:0]   app_mem_raddr,
    output logic [NCH-1:0]               app_mem_ack,
    output logic [NCH*WIDTH-1:0]         app_mem_rdata,
    output logic [NCH-1:0]               app_ovf,
    input  logic                         ovf_clr
);
    localparam int DEPTH = 1 << DEPTH_NBITS;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;

    logic [WIDTH-1:0]       ram [DEPTH];
    logic [WIDTH-1:0]       ram_dout;
    logic [DEPTH_NBITS-1:0] ram_raddr;
    logic                   ram_re;

    logic [NCH-1:0]         pend;
    logic [DEPTH_NBITS-1:0] app_idx [NCH];
    logic                   pio_pend;
    logic [DEPTH_NBITS-1:0] pio_idx;
    logic [3:0]             wait_cnt;
    logic [CW-1:0]          rr_ptr;
    logic [CW-1:0]          rr_next;

    logic                   pio_grant;
    logic                   app_hit;
    logic [NCH-1:0]         app_grant;
    logic [CW-1:0]          grant_ch;
    logic [CW-1:0]          scan_ch;

    logic                   s1_valid;
    logic                   s1_pio;
    logic [CW-1:0]          s1_ch;
    logic                   n_mem_ack;

    logic                   wr_en;
    logic                   pio_rd_ok;
    logic [DEPTH_NBITS-1:0] reg_idx;
    logic                   unused_bits;

    assign reg_idx     = reg_addr[DEPTH_NBITS+1:2];
    assign wr_en       = reg_ms & reg_wr;
    // A PIO read is only taken when no earlier PIO read is waiting or in the pipe.
    assign pio_rd_ok   = reg_ms & reg_rd & ~pio_pend & ~(s1_valid & s1_pio);
    assign unused_bits = ^{reg_addr[PIO_ADDR_MSB:0], reg_din};

    always_comb begin
        pio_grant = 1'b0;
        app_hit   = 1'b0;
        app_grant = '0;
        grant_ch  = '0;
        scan_ch   = '0;
        rr_next   = rr_ptr;
        if (pio_pend && wait_cnt == 4'(PIO_MAX_WAIT)) begin
            pio_grant = 1'b1;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                scan_ch = CW'((int'(rr_ptr) + k) % NCH);
                if (!app_hit && pend[scan_ch]) begin
                    app_hit  = 1'b1;
                    grant_ch = scan_ch;
                end
            end
            if (app_hit) begin
                app_grant[grant_ch] = 1'b1;
                rr_next = (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
            end else if (pio_pend) begin
                pio_grant = 1'b1;
            end
        end
        ram_re    = pio_grant | app_hit;
        ram_raddr = pio_grant ? pio_idx : app_idx[grant_ch];
    end

    // Read-first RAM: a same-cycle write to the read index returns the old entry.
    always_ff @(posedge clk) begin
        if (wr_en) ram[reg_idx] <= reg_din[WIDTH-1:0];
        if (ram_re) ram_dout <= ram[ram_raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend          <= '0;
            pio_pend      <= 1'b0;
            pio_idx       <= '0;
            wait_cnt      <= '0;
            rr_ptr        <= '0;
            app_ovf       <= '0;
            s1_valid      <= 1'b0;
            s1_pio        <= 1'b0;
            s1_ch         <= '0;
            app_mem_ack   <= '0;
            app_mem_rdata <= '0;
            mem_rdata     <= '0;
            n_mem_ack     <= 1'b0;
            mem_ack       <= 1'b0;
            for (int i = 0; i < NCH; i++) app_idx[i] <= '0;
        end else begin
            // A read on a channel whose request is still pending is dropped, even in its grant cycle.
            for (int i = 0; i < NCH; i++) begin
                if (app_mem_rd[i] && !pend[i]) begin
                    pend[i]    <= 1'b1;
                    app_idx[i] <= app_mem_raddr[i*DEPTH_NBITS +: DEPTH_NBITS];
                end else if (app_grant[i]) begin
                    pend[i] <= 1'b0;
                end
                if (app_mem_rd[i] && pend[i]) app_ovf[i] <= 1'b1;
                else if (ovf_clr)             app_ovf[i] <= 1'b0;
            end

            if (pio_rd_ok) begin
                pio_pend <= 1'b1;
                pio_idx  <= reg_idx;
            end else if (pio_grant) begin
                pio_pend <= 1'b0;
            end

            if (pio_grant)     wait_cnt <= '0;
            else if (pio_pend) wait_cnt <= wait_cnt + 1'b1;

            rr_ptr   <= rr_next;
            s1_valid <= ram_re;
            s1_pio   <= pio_grant;
            s1_ch    <= grant_ch;

            app_mem_ack <= '0;
            if (s1_valid && !s1_pio) begin
                app_mem_ack[s1_ch] <= 1'b1;
                app_mem_rdata[s1_ch*WIDTH +: WIDTH] <= ram_dout;
            end
            if (s1_valid && s1_pio) mem_rdata <= PIO_NBITS'(ram_dout);

            if (wr_en || (s1_valid && s1_pio)) n_mem_ack <= 1'b1;
            else if (clk_div)                  n_mem_ack <= 1'b0;
            if (clk_div) mem_ack <= n_mem_ack;
        end
    end
endmodule

// File: tb/tb_pio_mem_bram_mc.sv
// Directed bench for pio_mem_bram_mc: PIO access, round-robin app reads, PIO wait guard,
// overrun flags, read-first collision and mid-operation reset.
module tb_pio_mem_bram_mc;
    localparam int WIDTH = 20;
    localparam int DN    = 10;
    localparam int NCH   = 2;
    localparam int PN    = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_div = 1'b1;
    logic [PN-1:0]     reg_addr = '0;
    logic [PN-1:0]     reg_din = '0;
    logic              reg_rd = 1'b0;
    logic              reg_wr = 1'b0;
    logic              reg_ms = 1'b0;
    logic              mem_ack;
    logic [PN-1:0]     mem_rdata;
    logic [NCH-1:0]    app_mem_rd = '0;
    logic [NCH*DN-1:0] app_mem_raddr = '0;
    logic [NCH-1:0]    app_mem_ack;
    logic [NCH*WIDTH-1:0] app_mem_rdata;
    logic [NCH-1:0]    app_ovf;
    logic              ovf_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [NCH-1:0] any_ack;
    logic           any_pio_ack;

    pio_mem_bram_mc dut (
        .clk(clk), .rst(rst), .clk_div(clk_div),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
        .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
        .app_ovf(app_ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pio_write(input int idx, input logic [PN-1:0] d);
        reg_ms = 1'b1; reg_wr = 1'b1; reg_addr = PN'(idx) << 2; reg_din = d;
        cyc();
        reg_ms = 1'b0; reg_wr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("reset_mem_ack", mem_ack, 0);
        check("reset_mem_rdata", mem_rdata, 0);
        check("reset_app_ack", app_mem_ack, 0);
        check("reset_app_rdata", app_mem_rdata, 0);
        check("reset_app_ovf", app_ovf, 0);

        // Test 1: PIO write then read of idx 5; clk_div gates the ack update.
        clk_div = 1'b0;
        pio_write(5, 32'h12345);
        cyc();
        check("t1_ack_held_by_clk_div", mem_ack, 0);
        clk_div = 1'b1;
        cyc();
        check("t1_wr_ack", mem_ack, 1);
        cyc();
        check("t1_wr_ack_drop", mem_ack, 0);
        reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = 32'd5 << 2;
        cyc();
        reg_ms = 1'b0; reg_rd = 1'b0;
        cyc();
        cyc();
        check("t1_rdata", mem_rdata, 32'h00012345);
        check("t1_no_ack_yet", mem_ack, 0);
        cyc();
        check("t1_rd_ack", mem_ack, 1);

        // Preload entries used by later tests.
        pio_write(3, 32'hA);
        pio_write(7, 32'hB);
        pio_write(2, 32'h22222);
        pio_write(9, 32'h99999);
        pio_write(4, 32'h11);
        cyc(); cyc();

        // Test 2: both channels in the same cycle, round-robin from channel 0.
        app_mem_rd = 2'b11; app_mem_raddr = {10'd7, 10'd3};
        cyc();
        app_mem_rd = 2'b00;
        cyc();
        cyc();
        check("t2_ch0_ack", app_mem_ack, 2'b01);
        check("t2_ch0_data", app_mem_rdata[19:0], 20'hA);
        cyc();
        check("t2_ch1_ack", app_mem_ack, 2'b10);
        check("t2_ch1_data", app_mem_rdata[39:20], 20'hB);
        check("t2_ch0_data_held", app_mem_rdata[19:0], 20'hA);
        cyc();
        check("t2_ack_clear", app_mem_ack, 2'b00);

        // Test 3: continuous app reads starve PIO until the wait guard fires.
        app_mem_rd = 2'b11; app_mem_raddr = {10'd7, 10'd3};
        cyc(); cyc();
        reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = 32'd5 << 2;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            if (n == 1) begin
                reg_ms = 1'b0; reg_rd = 1'b0;
            end
            if (mem_ack) begin
                lat = n;
                break;
            end
        end
        check("t3_pio_rd_to_ack_cycles", lat, 8);
        check("t3_pio_rdata", mem_rdata, 32'h00012345);
        app_mem_rd = 2'b00;
        repeat (6) cyc();
        check("t3_ovf_both", app_ovf, 2'b11);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t3_ovf_cleared", app_ovf, 2'b00);

        // Test 4: back-to-back reads on channel 1 keep the first index and flag overrun.
        app_mem_rd = 2'b10; app_mem_raddr = {10'd2, 10'd0};
        cyc();
        app_mem_raddr = {10'd9, 10'd0};
        cyc();
        app_mem_rd = 2'b00;
        check("t4_ovf_set", app_ovf, 2'b10);
        cyc();
        check("t4_ack", app_mem_ack, 2'b10);
        check("t4_data_first_idx", app_mem_rdata[39:20], 20'h22222);
        cyc();
        check("t4_no_second_ack", app_mem_ack, 2'b00);
        cyc();
        check("t4_ovf_sticky", app_ovf, 2'b10);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t4_ovf_cleared", app_ovf, 2'b00);

        // Test 5: PIO write to idx 4 in the cycle channel 0 is granted idx 4.
        app_mem_rd = 2'b01; app_mem_raddr = {10'd0, 10'd4};
        cyc();
        app_mem_rd = 2'b00;
        pio_write(4, 32'h55);
        cyc();
        check("t5_ack", app_mem_ack, 2'b01);
        check("t5_read_first_old", app_mem_rdata[19:0], 20'h11);
        cyc();
        app_mem_rd = 2'b01; app_mem_raddr = {10'd0, 10'd4};
        cyc();
        app_mem_rd = 2'b00;
        cyc(); cyc();
        check("t5_later_ack", app_mem_ack, 2'b01);
        check("t5_later_new", app_mem_rdata[19:0], 20'h55);
        repeat (3) cyc();

        // Test 6: reset with two app reads and a PIO read outstanding.
        app_mem_rd = 2'b11; app_mem_raddr = {10'd7, 10'd3};
        reg_ms = 1'b1; reg_rd = 1'b1; reg_addr = 32'd5 << 2;
        cyc();
        app_mem_rd = 2'b10;
        reg_ms = 1'b0; reg_rd = 1'b0;
        cyc();
        app_mem_rd = 2'b00;
        check("t6_ovf_before_reset", app_ovf, 2'b10);
        rst = 1'b1;
        #1;
        check("t6_rst_app_ack", app_mem_ack, 0);
        check("t6_rst_mem_ack", mem_ack, 0);
        check("t6_rst_ovf", app_ovf, 0);
        check("t6_rst_mem_rdata", mem_rdata, 0);
        check("t6_rst_app_rdata", app_mem_rdata, 0);
        cyc(); cyc();
        rst = 1'b0;
        any_ack = '0;
        any_pio_ack = 1'b0;
        repeat (6) begin
            cyc();
            any_ack = any_ack | app_mem_ack;
            any_pio_ack = any_pio_ack | mem_ack;
        end
        check("t6_no_app_ack_after_reset", any_ack, 0);
        check("t6_no_pio_ack_after_reset", any_pio_ack, 0);
        app_mem_rd = 2'b01; app_mem_raddr = {10'd0, 10'd3};
        cyc();
        app_mem_rd = 2'b00;
        cyc();
        check("t6_no_early_ack", app_mem_ack, 2'b00);
        cyc();
        check("t6_post_reset_ack", app_mem_ack, 2'b01);
        check("t6_post_reset_data", app_mem_rdata[19:0], 20'hA);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
